// File: rtl/mic_spi_capture.sv
// SPI master front end for a 12-bit ADCS7476-style microphone ADC.
// Paces conversions from a sample timer and shifts in one 16-bit frame per conversion.
module mic_spi_capture #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 2500,
  parameter int QUIET_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sdata,
  output logic        sck,
  output logic        cs_n,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        overrun
);

  localparam int HW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int QW = (QUIET_CYC > 1)  ? $clog2(QUIET_CYC)  : 1;

  typedef enum logic [1:0] {IDLE, FRAME, QUIET} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer;
  logic [HW-1:0]   hcnt;
  logic [4:0]      bitcnt;
  logic [15:0]     shreg;
  logic [QW-1:0]   qcnt;
  logic            tick;
  logic            half_wrap;
  logic            frame_done;
  logic            quiet_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!enable) begin
      timer <= '0;
    end else if (timer == TW'(SAMPLE_DIV - 1)) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick)       state_next = FRAME;
      FRAME:   if (frame_done) state_next = QUIET;
      QUIET:   if (quiet_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tick       = enable && (timer == TW'(SAMPLE_DIV - 1));
    half_wrap  = (hcnt == HW'(CLK_DIV - 1));
    frame_done = (bitcnt == 5'd16);
    quiet_done = (qcnt == QW'(QUIET_CYC - 1));
    // Ticks outside IDLE are dropped; the strobe marks the lost conversion in the tick cycle.
    overrun    = tick && (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck          <= 1'b1;
      cs_n         <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      hcnt         <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      qcnt         <= '0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          sck    <= 1'b1;
          hcnt   <= '0;
          bitcnt <= '0;
          qcnt   <= '0;
          if (tick) begin
            cs_n  <= 1'b0;
            shreg <= '0;
          end
        end
        FRAME: begin
          if (frame_done) begin
            cs_n         <= 1'b1;
            sck          <= 1'b1;
            sample       <= shreg[11:0];
            sample_valid <= 1'b1;
            frame_err    <= |shreg[15:12];
            qcnt         <= '0;
          end else if (half_wrap) begin
            hcnt <= '0;
            sck  <= ~sck;
            // A wrap while sck is low is the rising edge: capture in the same cycle.
            if (!sck) begin
              shreg  <= {shreg[14:0], sdata};
              bitcnt <= bitcnt + 5'd1;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        QUIET: begin
          cs_n <= 1'b1;
          sck  <= 1'b1;
          if (!quiet_done) qcnt <= qcnt + QW'(1);
        end
        default: begin
          cs_n <= 1'b1;
          sck  <= 1'b1;
        end
      endcase
    end
  end

endmodule
